// File: rtl/vend_pkg.sv
// Shared types and constants for the coin change dispenser.
package vend_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSelect,
      StEject,
      StRelease,
      StDone,
      StFault
   } state_e;

   localparam logic [2:0] Coin1Val = 3'd1;
   localparam logic [2:0] Coin2Val = 3'd2;
   localparam logic [2:0] Coin5Val = 3'd5;

   // eject_req encoding: bit2=5k, bit1=2k, bit0=1k
   localparam logic [2:0] Coin1Oh = 3'b001;
   localparam logic [2:0] Coin2Oh = 3'b010;
   localparam logic [2:0] Coin5Oh = 3'b100;

   localparam int unsigned AckTimeoutDefault = 8;

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest coin not above the remaining value that is still in stock.
module coin_select
   import vend_pkg::*;
(
   input  logic [3:0] remaining_i,
   input  logic [3:0] inv1_i,
   input  logic [3:0] inv2_i,
   input  logic [3:0] inv5_i,
   output logic [2:0] pick_o,
   output logic [2:0] value_o
);

   always_comb begin
      pick_o  = '0;
      value_o = '0;
      if (remaining_i >= {1'b0, Coin5Val} && inv5_i != 4'd0) begin
         pick_o  = Coin5Oh;
         value_o = Coin5Val;
      end else if (remaining_i >= {1'b0, Coin2Val} && inv2_i != 4'd0) begin
         pick_o  = Coin2Oh;
         value_o = Coin2Val;
      end else if (remaining_i >= {1'b0, Coin1Val} && inv1_i != 4'd0) begin
         pick_o  = Coin1Oh;
         value_o = Coin1Val;
      end
   end

endmodule

// File: rtl/coin_change_dispenser.sv
// Dispenses change coin by coin through an acknowledged eject mechanism, tracking
// per-type inventory and reporting any value that could not be paid out.
module coin_change_dispenser
   import vend_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = AckTimeoutDefault
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic [3:0] amount_i,
   output logic       ready_o,
   output logic       done_o,
   output logic       short_o,
   output logic [3:0] shortfall_o,
   output logic [2:0] eject_req_o,
   input  logic       eject_ack_i,
   output logic       fault_o,
   input  logic       refill_i,
   input  logic [3:0] inv1_i,
   input  logic [3:0] inv2_i,
   input  logic [3:0] inv5_i,
   output logic [3:0] c1_o,
   output logic [3:0] c2_o,
   output logic [3:0] c5_o
);

   localparam int unsigned TimerW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TimerW-1:0] TimerLast = TimerW'(ACK_TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [3:0]        remaining_q, remaining_d;
   logic [3:0]        inv1_q, inv1_d, inv2_q, inv2_d, inv5_q, inv5_d;
   logic [3:0]        c1_q, c1_d, c2_q, c2_d, c5_q, c5_d;
   logic [2:0]        pick_q, pick_d;
   logic [2:0]        val_q, val_d;
   logic [TimerW-1:0] timer_q, timer_d;

   logic [2:0]        sel_pick;
   logic [2:0]        sel_val;

   coin_select u_coin_select (
      .remaining_i (remaining_q),
      .inv1_i      (inv1_q),
      .inv2_i      (inv2_q),
      .inv5_i      (inv5_q),
      .pick_o      (sel_pick),
      .value_o     (sel_val)
   );

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      inv1_d      = inv1_q;
      inv2_d      = inv2_q;
      inv5_d      = inv5_q;
      c1_d        = c1_q;
      c2_d        = c2_q;
      c5_d        = c5_q;
      pick_d      = pick_q;
      val_d       = val_q;
      timer_d     = timer_q;

      unique case (state_q)
         StIdle: begin
            // refill takes priority and drops a coincident start
            if (refill_i) begin
               inv1_d = inv1_i;
               inv2_d = inv2_i;
               inv5_d = inv5_i;
            end else if (start_i) begin
               remaining_d = amount_i;
               c1_d        = '0;
               c2_d        = '0;
               c5_d        = '0;
               state_d     = StSelect;
            end
         end
         StSelect: begin
            if (remaining_q == 4'd0 || sel_pick == 3'b000) begin
               state_d = StDone;
            end else begin
               pick_d  = sel_pick;
               val_d   = sel_val;
               timer_d = '0;
               state_d = StEject;
            end
         end
         StEject: begin
            if (eject_ack_i) begin
               remaining_d = remaining_q - {1'b0, val_q};
               if (pick_q == Coin5Oh && inv5_q != 4'd0) begin
                  inv5_d = inv5_q - 4'd1;
                  c5_d   = c5_q + 4'd1;
               end else if (pick_q == Coin2Oh && inv2_q != 4'd0) begin
                  inv2_d = inv2_q - 4'd1;
                  c2_d   = c2_q + 4'd1;
               end else if (pick_q == Coin1Oh && inv1_q != 4'd0) begin
                  inv1_d = inv1_q - 4'd1;
                  c1_d   = c1_q + 4'd1;
               end
               state_d = StRelease;
            end else if (timer_q == TimerLast) begin
               state_d = StFault;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StRelease: begin
            if (!eject_ack_i) begin
               state_d = StSelect;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         StFault: begin
            if (refill_i) begin
               inv1_d  = inv1_i;
               inv2_d  = inv2_i;
               inv5_d  = inv5_i;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         inv1_q      <= '0;
         inv2_q      <= '0;
         inv5_q      <= '0;
         c1_q        <= '0;
         c2_q        <= '0;
         c5_q        <= '0;
         pick_q      <= '0;
         val_q       <= '0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         inv1_q      <= inv1_d;
         inv2_q      <= inv2_d;
         inv5_q      <= inv5_d;
         c1_q        <= c1_d;
         c2_q        <= c2_d;
         c5_q        <= c5_d;
         pick_q      <= pick_d;
         val_q       <= val_d;
         timer_q     <= timer_d;
      end
   end

   assign ready_o     = (state_q == StIdle);
   assign done_o      = (state_q == StDone);
   assign short_o     = done_o && (remaining_q != 4'd0);
   assign shortfall_o = done_o ? remaining_q : 4'd0;
   assign eject_req_o = (state_q == StEject) ? pick_q : 3'b000;
   assign fault_o     = (state_q == StFault);
   assign c1_o        = c1_q;
   assign c2_o        = c2_q;
   assign c5_o        = c5_q;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Scoreboard bench: a greedy change model queues expected ejects and done results,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_coin_change_dispenser;

   typedef struct {
      int sh;
      int sf;
      int c1;
      int c2;
      int c5;
   } done_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] amount;
   logic       ready;
   logic       done;
   logic       short_w;
   logic [3:0] shortfall;
   logic [2:0] eject_req;
   logic       eject_ack;
   logic       fault;
   logic       refill;
   logic [3:0] inv1, inv2, inv5;
   logic [3:0] c1, c2, c5;

   int    tests = 0;
   int    fails = 0;
   int    exp_ej[$];
   done_t exp_dn[$];
   int    m_inv1 = 0, m_inv2 = 0, m_inv5 = 0;
   bit    ack_en = 1'b1;
   int    ack_wait = 0;
   logic [2:0] mon_prev = 3'b000;

   coin_change_dispenser #(.ACK_TIMEOUT(8)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .amount_i    (amount),
      .ready_o     (ready),
      .done_o      (done),
      .short_o     (short_w),
      .shortfall_o (shortfall),
      .eject_req_o (eject_req),
      .eject_ack_i (eject_ack),
      .fault_o     (fault),
      .refill_i    (refill),
      .inv1_i      (inv1),
      .inv2_i      (inv2),
      .inv5_i      (inv5),
      .c1_o        (c1),
      .c2_o        (c2),
      .c5_o        (c5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: pay greedily from the largest coin in stock, coin values 5/2/1.
   task automatic model_dispense(input int amt);
      int rem = amt;
      int n1 = 0, n2 = 0, n5 = 0;
      done_t d;
      while (rem > 0) begin
         if (rem >= 5 && m_inv5 > 0) begin
            rem -= 5; m_inv5--; n5++; exp_ej.push_back(4);
         end else if (rem >= 2 && m_inv2 > 0) begin
            rem -= 2; m_inv2--; n2++; exp_ej.push_back(2);
         end else if (rem >= 1 && m_inv1 > 0) begin
            rem -= 1; m_inv1--; n1++; exp_ej.push_back(1);
         end else begin
            break;
         end
      end
      d.sh = (rem != 0) ? 1 : 0;
      d.sf = rem;
      d.c1 = n1;
      d.c2 = n2;
      d.c5 = n5;
      exp_dn.push_back(d);
   endtask

   // Mechanism: ack after a random 0..3 cycle delay, drop once the request is released.
   initial begin
      eject_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (ack_en && eject_req != 3'b000 && !eject_ack) begin
            if (ack_wait == 0) eject_ack = 1'b1;
            else ack_wait--;
         end else if (eject_req == 3'b000 && eject_ack) begin
            eject_ack = 1'b0;
            ack_wait  = $urandom_range(0, 3);
         end
      end
   end

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         if (eject_req != 3'b000 && mon_prev == 3'b000) begin
            if (exp_ej.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL eject_unexpected: got %b expected none", eject_req);
            end else begin
               check("eject_coin", int'(eject_req), exp_ej.pop_front());
            end
         end
         if (done) begin
            if (exp_dn.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL done_unexpected: got done=1 expected none");
            end else begin
               done_t d;
               d = exp_dn.pop_front();
               check("done_short", int'(short_w), d.sh);
               check("done_shortfall", int'(shortfall), d.sf);
               check("done_c1", int'(c1), d.c1);
               check("done_c2", int'(c2), d.c2);
               check("done_c5", int'(c5), d.c5);
            end
         end else if (short_w) begin
            tests++;
            fails++;
            $display("FAIL short_without_done: got short=1 expected 0");
         end
         mon_prev = eject_req;
      end
   end

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_refill(input int a1, input int a2, input int a5);
      refill = 1'b1;
      inv1 = 4'(a1);
      inv2 = 4'(a2);
      inv5 = 4'(a5);
      m_inv1 = a1;
      m_inv2 = a2;
      m_inv5 = a5;
      cycles(1);
      refill = 1'b0;
   endtask

   task automatic pulse_start(input int amt);
      start = 1'b1;
      amount = 4'(amt);
      cycles(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got no done expected done", name);
      end
      cycles(1);
   endtask

   task automatic dispense(input string name, input int amt);
      model_dispense(amt);
      pulse_start(amt);
      wait_done(name);
   endtask

   initial begin
      int cnt;
      bit seen;
      logic [2:0] prev;
      rst_n = 1'b0;
      start = 1'b0;
      amount = '0;
      refill = 1'b0;
      inv1 = '0;
      inv2 = '0;
      inv5 = '0;
      #12;
      check("rst_ready", int'(ready), 1);
      check("rst_eject_req", int'(eject_req), 0);
      check("rst_done", int'(done), 0);
      check("rst_fault", int'(fault), 0);
      check("rst_shortfall", int'(shortfall), 0);
      check("rst_c_sum", int'(c1) + int'(c2) + int'(c5), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycles(1);

      // Full change 8k and 13k, then a 1k-only shortage
      do_refill(5, 5, 5);
      dispense("full8", 8);
      do_refill(5, 5, 5);
      dispense("full13", 13);
      do_refill(2, 0, 0);
      dispense("shortage", 4);
      dispense("zero", 0);

      // start while busy is ignored
      do_refill(5, 5, 5);
      model_dispense(13);
      pulse_start(13);
      cycles(3);
      check("busy_ready", int'(ready), 0);
      pulse_start(15);
      wait_done("busy");

      // refill and start together: refill wins
      refill = 1'b1;
      start = 1'b1;
      amount = 4'd3;
      inv1 = 4'd1;
      inv2 = 4'd1;
      inv5 = 4'd1;
      m_inv1 = 1;
      m_inv2 = 1;
      m_inv5 = 1;
      cycles(1);
      refill = 1'b0;
      start = 1'b0;
      cycles(4);
      check("collide_ready", int'(ready), 1);
      dispense("after_collide", 8);

      // Ack timeout into fault
      ack_en = 1'b0;
      do_refill(3, 3, 3);
      exp_ej.push_back(4);
      pulse_start(5);
      cnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (eject_req != 3'b000) begin
            cnt++;
            seen = 1'b1;
         end else if (seen) begin
            break;
         end
      end
      check("timeout_cycles", cnt, 8);
      check("timeout_fault", int'(fault), 1);
      check("timeout_req_low", int'(eject_req), 0);
      cycles(1);
      pulse_start(1);
      cycles(3);
      check("fault_sticky", int'(fault), 1);
      check("fault_not_ready", int'(ready), 0);
      do_refill(2, 2, 2);
      #3;
      check("fault_cleared", int'(fault), 0);
      check("fault_ready", int'(ready), 1);
      ack_en = 1'b1;
      cycles(1);
      dispense("after_fault", 9);

      // Reset during the second eject of 13k
      do_refill(5, 5, 5);
      exp_ej.push_back(4);
      exp_ej.push_back(4);
      pulse_start(13);
      cnt = 0;
      prev = 3'b000;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (eject_req != 3'b000 && prev == 3'b000) cnt++;
         prev = eject_req;
         if (cnt == 2) break;
      end
      check("rst_mid_second_eject", cnt, 2);
      #1;
      rst_n = 1'b0;
      m_inv1 = 0;
      m_inv2 = 0;
      m_inv5 = 0;
      #1;
      check("rst_mid_req", int'(eject_req), 0);
      check("rst_mid_ready", int'(ready), 1);
      check("rst_mid_c5", int'(c5), 0);
      check("rst_mid_c_sum", int'(c1) + int'(c2), 0);
      cycles(2);
      rst_n = 1'b1;
      cycles(3);
      check("rst_mid_ej_drained", exp_ej.size(), 0);
      dispense("empty_inv", 3);

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            do_refill($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
         end else begin
            dispense("rand", $urandom_range(0, 15));
         end
      end

      cycles(4);
      check("end_ej_queue", exp_ej.size(), 0);
      check("end_dn_queue", exp_dn.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/coin_change_dispenser.md
COIN_CHANGE_DISPENSER -- requirements
Module: coin_change_dispenser

Interface
REQ-001 The block SHALL use one clock and asynchronous active-low reset, as these ports:
- clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low
REQ-002 Request and status ports SHALL be:
- start  in  1  one-cycle request to dispense amount
- amount  in  4  change value in 1k units, 0..15
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse, dispense completed
- short  out  1  one-cycle pulse, with done, when change is incomplete
- shortfall  out  4  undispensed value, valid while done=1
REQ-003 Mechanism and inventory ports SHALL be:
- eject_req  out  3  one-hot, bit2=5k, bit1=2k, bit0=1k
- eject_ack  in  1  mechanism acknowledge
- fault  out  1  ack timeout, sticky
- refill  in  1  one-cycle inventory load
- inv1_in, inv2_in, inv5_in  in  4 each  refill counts
- C1, C2, C5  out  4 each  coins of each type issued in the current or last dispense
REQ-004 Parameter ACK_TIMEOUT (default 8) SHALL set the cycles allowed for eject_ack.

Function
REQ-005 States SHALL be IDLE, SELECT, EJECT, RELEASE, DONE and FAULT.
REQ-006 In IDLE, start=1 with refill=0 SHALL:
- latch amount into remaining
- clear C1, C2 and C5
- move to SELECT on the next edge
REQ-007 start SHALL be ignored outside IDLE.
REQ-008 In SELECT the coin SHALL be picked greedily as the largest value <= remaining whose inventory is nonzero, in the order 5k, 2k, 1k.
REQ-009 SELECT transitions SHALL be:
- remaining=0 -> DONE
- no coin eligible -> DONE with short
- coin picked -> EJECT
REQ-010 In EJECT, eject_req SHALL hold the picked one-hot bit until eject_ack=1.
REQ-011 On that ack edge the block SHALL:
- subtract the coin value from remaining
- decrement that coin's inventory
- increment its C counter
- move to RELEASE
REQ-012 RELEASE SHALL drive eject_req=0 and return to SELECT after the first cycle with eject_ack=0.
REQ-013 If eject_ack stays 0 for ACK_TIMEOUT consecutive EJECT cycles, the block SHALL go to FAULT and drive eject_req=0.
REQ-014 FAULT SHALL assert fault and hold there until refill=1, which returns the block to IDLE.
REQ-015 In DONE the block SHALL:
- pulse done for one cycle
- pulse short if remaining != 0
- drive shortfall with remaining
- return to IDLE
REQ-016 Latency SHALL be as follows:
- amount=0 -> done on the 2nd edge after start
- each coin adds 2 cycles plus mechanism ack time
REQ-017 refill in IDLE or FAULT SHALL load all three inventories.
REQ-018 refill SHALL be ignored in other states.
REQ-019 When refill and start occur in the same IDLE cycle, refill SHALL win and start SHALL be dropped.
REQ-020 At most one eject_req bit SHALL ever be high.
REQ-021 eject_req SHALL never be high outside EJECT.
REQ-022 Inventory counters SHALL never wrap below 0.

Reset
REQ-023 Reset=0 SHALL at once, regardless of state, force:
- state IDLE and ready=1
- eject_req=0, done=0, short=0, fault=0
- shortfall=0
- C1=C2=C5=0
- all inventories 0
REQ-024 Reset during EJECT SHALL abandon the dispense with no further pulses after release.

Structure
REQ-025 Package vend_pkg SHALL hold:
- the state enum
- coin value constants (1, 2, 5)
- one-hot coin encodings
- the ACK_TIMEOUT default
REQ-026 Greedy selection SHALL be a combinational sub-module coin_select (inputs remaining and three inventories; outputs one-hot pick and value). All registers stay in coin_change_dispenser.

Verification
REQ-027 Full change, 8k: inventory 5/5/5, amount=8, ack 1 cycle after each req -> ejects 5k, 2k, 1k; C5=C2=C1=1; done with short=0; inventory 4/4/4.
REQ-028 Full change, 13k: inventory 5/5/5, amount=13 -> ejects 5k, 5k, 2k, 1k; C5=2, C2=1, C1=1; done.
REQ-029 Shortage: inventory 5k=0, 2k=0, 1k=2, amount=4 -> two 1k ejects, then done+short with shortfall=2.
REQ-030 Ack timeout: eject_ack held 0 -> eject_req drops after 8 EJECT cycles; fault=1; start ignored; refill clears fault and restores ready=1.
REQ-031 Reset mid-dispense: Reset low during 2nd EJECT of amount=13 -> eject_req=0 at once; ready=1; C and inventory counts 0.
REQ-032 Request collisions:
- start pulsed while busy -> ignored, counts unchanged
- refill+start in the same IDLE cycle -> inventories loaded, no dispense
